unidade_controle: RTL



---
 rtl/unidade_controle.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Control unit for the multicycle processor.
// A 3-bit step register walks fetch (T0-T2) and execute (T3-T5); every
// datapath enable is a combinational decode of the current step, IR, GNZ
// and Run. Instruction word: IR[8:6] opcode, IR[5:3] Rx, IR[2:0] Ry.
//
// state | meaning
// T0    | idle while Run=0; with Run=1 drive PC (R7) onto the bus, load ADDR
// T1    | memory read latency, increment PC
// T2    | load IR from DIN
// T3    | first execute step (mv/mvnz/nop finish here)
// T4    | second execute step
// T5    | last execute step of mvi/add/sub/ld/st
module unidade_controle (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    input  logic       GNZ,
    output logic [2:0] Tstep,
    output logic [7:0] Rout,
    output logic       Gout,
    output logic       DINout,
    output logic [7:0] Rin,
    output logic       Ain,
    output logic       Gin,
    output logic       IRin,
    output logic       Ulaop,
    output logic       ADDRin,
    output logic       DOUTin,
    output logic       W_D,
    output logic       IncrPc,
    output logic       Done
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } step_e;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b110;

    step_e      step_q;
    step_e      step_d;

    logic [2:0] opcode;
    logic [7:0] rx_oh;
    logic [7:0] ry_oh;

    logic [7:0] rout_c;
    logic [7:0] rin_c;
    logic       gout_c;
    logic       dinout_c;
    logic       ain_c;
    logic       gin_c;
    logic       irin_c;
    logic       ulaop_c;
    logic       addrin_c;
    logic       doutin_c;
    logic       wd_c;
    logic       incrpc_c;
    logic       done_c;

    assign opcode = IR[8:6];
    assign rx_oh  = 8'(1) << IR[5:3];
    assign ry_oh  = 8'(1) << IR[2:0];

    // Step register; reset abandons any instruction in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    // Next-step and per-step enable decode.
    always_comb begin
        step_d   = step_q;
        rout_c   = '0;
        rin_c    = '0;
        gout_c   = 1'b0;
        dinout_c = 1'b0;
        ain_c    = 1'b0;
        gin_c    = 1'b0;
        irin_c   = 1'b0;
        ulaop_c  = 1'b0;
        addrin_c = 1'b0;
        doutin_c = 1'b0;
        wd_c     = 1'b0;
        incrpc_c = 1'b0;
        done_c   = 1'b0;

        case (step_q)
            T0: begin
                // Run is only looked at here; once fetch starts it completes.
                if (Run) begin
                    rout_c[7] = 1'b1;
                    addrin_c  = 1'b1;
                    step_d    = T1;
                end
            end
            T1: begin
                incrpc_c = 1'b1;
                step_d   = T2;
            end
            T2: begin
                irin_c = 1'b1;
                step_d = T3;
            end
            T3: begin
                step_d = T4;
                case (opcode)
                    OP_MV: begin
                        rout_c = ry_oh;
                        rin_c  = rx_oh;
                        done_c = 1'b1;
                    end
                    OP_MVI: begin
                        // PC already points at the immediate word.
                        rout_c[7] = 1'b1;
                        addrin_c  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_c = rx_oh;
                        ain_c  = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (GNZ) begin
                            rout_c = ry_oh;
                            rin_c  = rx_oh;
                        end
                        done_c = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        rout_c   = ry_oh;
                        addrin_c = 1'b1;
                    end
                    default: begin
                        done_c = 1'b1;
                    end
                endcase
            end
            T4: begin
                step_d = T5;
                case (opcode)
                    OP_MVI: begin
                        incrpc_c = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_c  = ry_oh;
                        gin_c   = 1'b1;
                        ulaop_c = IR[6];
                    end
                    OP_LD: begin
                        // memory read latency, nothing enabled
                    end
                    OP_ST: begin
                        rout_c   = rx_oh;
                        doutin_c = 1'b1;
                    end
                    default: begin
                        // short instruction cannot reach T4; recover to fetch
                        step_d = T0;
                    end
                endcase
            end
            T5: begin
                step_d = T0;
                case (opcode)
                    OP_MVI, OP_LD: begin
                        dinout_c = 1'b1;
                        rin_c    = rx_oh;
                        done_c   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        gout_c = 1'b1;
                        rin_c  = rx_oh;
                        done_c = 1'b1;
                    end
                    OP_ST: begin
                        wd_c   = 1'b1;
                        done_c = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                step_d = T0;
            end
        endcase

        if (done_c) begin
            step_d = T0;
        end
    end

    // Outputs are forced low for as long as reset is held, independent of the clock.
    assign Tstep  = step_q;
    assign Rout   = Resetn ? rout_c : 8'h00;
    assign Rin    = Resetn ? rin_c  : 8'h00;
    assign Gout   = Resetn & gout_c;
    assign DINout = Resetn & dinout_c;
    assign Ain    = Resetn & ain_c;
    assign Gin    = Resetn & gin_c;
    assign IRin   = Resetn & irin_c;
    assign Ulaop  = Resetn & ulaop_c;
    assign ADDRin = Resetn & addrin_c;
    assign DOUTin = Resetn & doutin_c;
    assign W_D    = Resetn & wd_c;
    assign IncrPc = Resetn & incrpc_c;
    assign Done   = Resetn & done_c;

endmodule
